seletor_jogo: RTL
=================

# seletor_jogo

Parametrised game selector for the LED-matrix display path. It synchronises and debounces two push-buttons (next/previous) in the system clock domain and steps through a configurable table of game patterns with wrap-around in both directions. It drives the active-low column bus of the matrix scanner. It replaces button-clocked selection logic with a fully synchronous design that supports any number of games and any matrix geometry.

## Interface
- N_JOGOS, 4: number of games in the pattern table; must be ≥ 2.
- COLUNAS, 5: number of matrix columns.
- LINHAS, 7: LEDs per column; LEDs are active-low.
- DEBOUNCE_CICLOS, 16: number of consecutive stable synchronised samples required to accept a button level change; must be ≥ 1.
- PADROES, four standard games: flat table, N_JOGOS*COLUNAS*LINHAS bits.
  - Game g, column c (c=0 is column 1) sits at [(g*COLUNAS+c)*LINHAS +: LINHAS].
  - Game 0 default: 0111100, 0011101, 0110101, 1000111, 1110111.
  - Game 1 default: 0001101, 1011100, 1011101, 1110111, 1000111.
  - Game 2 default: 0111000, 0001110, 0111111, 1111101, 1111000.
  - Game 3 default: 1100011, 1110111, 1111101, 0111101, 0001000.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- botao_prox  in  1  raw "next game" button, active-high, asynchronous to clk.
- botao_ant  in  1  raw "previous game" button, active-high, asynchronous to clk.
- limpar  in  1  synchronous one-cycle request to blank the display.
- colunas  out  COLUNAS*LINHAS  column pattern; column c at [c*LINHAS +: LINHAS]; all ones = blank.
- jogo_atual  out  max(1,$clog2(N_JOGOS))  index of the displayed game.
- exibindo  out  1  high while a game is displayed.
- troca  out  1  one-cycle pulse in the cycle where colunas takes a new game.

## Operation
- Each button passes through a 2-flop synchroniser, then the debouncer, then a rising-edge detector.
  - The debouncer holds an accepted level and a counter.
  - The counter resets whenever the synchronised input equals the accepted level.
  - When the counter reaches DEBOUNCE_CICLOS-1 while the input differs, the accepted level flips.
  - The edge detector produces one pulse per accepted 0→1 transition. Release produces nothing.
- State machine, two states:
  - VAZIO (reset state): colunas is all ones, exibindo=0, jogo_atual=0.
    - A next pulse goes to EXIBINDO with game 0.
    - A previous pulse goes to EXIBINDO with game N_JOGOS-1.
  - EXIBINDO: colunas shows the pattern of jogo_atual.
    - A next pulse increments the index; N_JOGOS-1 wraps to 0.
    - A previous pulse decrements the index; 0 wraps to N_JOGOS-1.
    - limpar returns to VAZIO.
- Priority in any one cycle:
  1. limpar wins over any button pulse. From VAZIO, limpar is a no-op.
  2. Next and previous pulses in the same cycle cancel; state is unchanged and troca=0.
- troca=1 for every game load, including a wrap back to the same game when N_JOGOS would allow it. troca=0 on limpar.
- The index arithmetic is modulo N_JOGOS, not a power of two. An index ≥ N_JOGOS is unreachable.
- Reset values:
  - colunas = all ones; jogo_atual = 0; exibindo = 0; troca = 0.
  - Synchronisers, accepted levels and counters all cleared.
  - A button held through reset release is accepted as a level change and produces a pulse after debounce.

## Timing
- All outputs are registered.
- With debounce, latency from the first clk edge sampling a stable high button to colunas/troca updating is 2 + DEBOUNCE_CICLOS + 1 cycles.
- Without debounce, that latency is 3 cycles.
- Glitches shorter than DEBOUNCE_CICLOS samples are rejected.
- limpar takes effect on the next edge: colunas is all ones one cycle after limpar is sampled.
- Reset asserted mid-debounce or mid-display blanks the outputs immediately (asynchronously). The in-progress count is discarded.

## Configuration
- SELETOR_DEBOUNCE_EN:
  - Defined: the debouncer is present, as described above.
  - Undefined: the debouncer is compiled out. The synchronised level feeds the edge detector directly, DEBOUNCE_CICLOS is ignored, and latency is 3 cycles.

## Test plan
- Reset, then pulse botao_prox and hold it 20 cycles (default parameters):
  - colunas = {1110111,1000111,0110101,0011101,0111100} (column 5 in the MSBs), jogo_atual=0, exibindo=1, troca pulses once, 2+16+1 cycles after the press.
- Four more clean next presses:
  - The index goes 1, 2, 3, 0.
  - After the press that reaches game 3, colunas column 5 = 0001000. The last press wraps to game 0.
- From reset, one previous press:
  - jogo_atual=3, column 1 = 1100011.
  - A second previous press gives jogo_atual=2.
- Glitch test: a 10-cycle high pulse on botao_prox:
  - No change and no troca.
  - Without SELETOR_DEBOUNCE_EN, the same pulse advances the game.
- Simultaneous presses:
  - Both buttons pressed with identical timing: state unchanged, troca=0.
  - limpar coinciding with a next pulse: colunas becomes all ones and exibindo=0.
- Reset asserted while displaying game 2 mid-debounce of a next press:
  - Outputs go to blank, jogo_atual=0, exibindo=0 immediately.
  - After release with the button still held, game 0 loads after 2+16+1 cycles.

Source files
------------

// File: rtl/seletor_jogo.sv
// seletor_jogo -- game selector for the LED-matrix display path.
//
// Synchronises the two raw push-buttons into clk, optionally debounces them,
// turns each accepted press into a one-cycle pulse, and uses those pulses to
// step through a table of column patterns with wrap-around in both directions.
//
// Optional feature macro: SELETOR_DEBOUNCE_EN
//   defined   -> each button needs DEBOUNCE_CICLOS stable synchronised samples
//                before a level change is accepted (press-to-load 2+D+1 cycles)
//   undefined -> the synchronised level feeds the edge detector directly
//                (press-to-load 3 cycles); DEBOUNCE_CICLOS is not used.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   botao_prox  raw "next game" button, active-high, asynchronous
//   botao_ant   raw "previous game" button, active-high, asynchronous
//   limpar      one-cycle request to blank the display
//   colunas     column bus, column c at [c*LINHAS +: LINHAS], active-low LEDs
//   jogo_atual  index of the displayed game
//   exibindo    high while a game is displayed
//   troca       one-cycle pulse when colunas takes a new game
module seletor_jogo #(
  parameter int N_JOGOS         = 4,
  parameter int COLUNAS         = 5,
  parameter int LINHAS          = 7,
  parameter int DEBOUNCE_CICLOS = 16,
  parameter logic [N_JOGOS*COLUNAS*LINHAS-1:0] PADROES = {
    7'b0001000, 7'b0111101, 7'b1111101, 7'b1110111, 7'b1100011,  // game 3, col 5..1
    7'b1111000, 7'b1111101, 7'b0111111, 7'b0001110, 7'b0111000,  // game 2
    7'b1000111, 7'b1110111, 7'b1011101, 7'b1011100, 7'b0001101,  // game 1
    7'b1110111, 7'b1000111, 7'b0110101, 7'b0011101, 7'b0111100   // game 0
  }
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        botao_prox,
  input  logic                                        botao_ant,
  input  logic                                        limpar,
  output logic [COLUNAS*LINHAS-1:0]                   colunas,
  output logic [(N_JOGOS > 1 ? $clog2(N_JOGOS) : 1)-1:0] jogo_atual,
  output logic                                        exibindo,
  output logic                                        troca
);

  localparam int IW = (N_JOGOS > 1) ? $clog2(N_JOGOS) : 1;
  localparam int GW = COLUNAS * LINHAS;
  localparam logic [IW-1:0] ULTIMO = IW'(N_JOGOS - 1);

  genvar gi;

  // Parameter sanity checks, evaluated at elaboration.
  if (N_JOGOS < 2) begin : g_chk_jogos
    $error("seletor_jogo: N_JOGOS must be >= 2");
  end
  if (DEBOUNCE_CICLOS < 1) begin : g_chk_debounce
    $error("seletor_jogo: DEBOUNCE_CICLOS must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Button front end: bit 0 = next, bit 1 = previous.
  // ---------------------------------------------------------------------
  logic [1:0] bruto;
  logic [1:0] pulso;

  assign bruto = {botao_ant, botao_prox};

  for (gi = 0; gi < 2; gi++) begin : g_botao
    logic sync1_reg;
    logic sync2_reg;
    logic nivel;
    logic nivel_d_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
      end else begin
        sync1_reg <= bruto[gi];
        sync2_reg <= sync1_reg;
      end
    end

`ifdef SELETOR_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;

    logic          aceito_reg;
    logic [CW-1:0] cont_reg;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts it, so short glitches die.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        aceito_reg <= 1'b0;
        cont_reg   <= '0;
      end else if (sync2_reg == aceito_reg) begin
        cont_reg <= '0;
      end else if (cont_reg == CW'(DEBOUNCE_CICLOS - 1)) begin
        aceito_reg <= sync2_reg;
        cont_reg   <= '0;
      end else begin
        cont_reg <= cont_reg + CW'(1);
      end
    end

    assign nivel = aceito_reg;
`else
    assign nivel = sync2_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        nivel_d_reg <= 1'b0;
      end else begin
        nivel_d_reg <= nivel;
      end
    end

    // Press only; release produces nothing.
    assign pulso[gi] = nivel & ~nivel_d_reg;
  end

  // ---------------------------------------------------------------------
  // Pattern table unpacked into one entry per game.
  // ---------------------------------------------------------------------
  logic [GW-1:0] padrao [N_JOGOS];

  for (gi = 0; gi < N_JOGOS; gi++) begin : g_padrao
    assign padrao[gi] = PADROES[gi*GW +: GW];
  end

  // ---------------------------------------------------------------------
  // Selection state machine.
  // ---------------------------------------------------------------------
  typedef enum logic {VAZIO, EXIBINDO} estado_t;

  estado_t       estado_reg, estado_next;
  logic [IW-1:0] jogo_reg, jogo_next;
  logic [GW-1:0] colunas_reg, colunas_next;
  logic          troca_reg, troca_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_reg  <= VAZIO;
      jogo_reg    <= '0;
      colunas_reg <= '1;
      troca_reg   <= 1'b0;
    end else begin
      estado_reg  <= estado_next;
      jogo_reg    <= jogo_next;
      colunas_reg <= colunas_next;
      troca_reg   <= troca_next;
    end
  end

  always_comb begin
    estado_next  = estado_reg;
    jogo_next    = jogo_reg;
    troca_next   = 1'b0;
    colunas_next = '1;

    if (limpar) begin
      // Blanking beats any button pulse; from VAZIO this changes nothing.
      estado_next = VAZIO;
      jogo_next   = '0;
    end else if (pulso[0] ^ pulso[1]) begin
      // Simultaneous next+previous cancel out, hence the XOR.
      troca_next  = 1'b1;
      estado_next = EXIBINDO;
      if (estado_reg == VAZIO) begin
        jogo_next = pulso[0] ? '0 : ULTIMO;
      end else if (pulso[0]) begin
        jogo_next = (jogo_reg == ULTIMO) ? '0 : jogo_reg + IW'(1);
      end else begin
        jogo_next = (jogo_reg == '0) ? ULTIMO : jogo_reg - IW'(1);
      end
    end

    if (estado_next == EXIBINDO) begin
      colunas_next = padrao[jogo_next];
    end
  end

  assign colunas    = colunas_reg;
  assign jogo_atual = jogo_reg;
  assign exibindo   = (estado_reg == EXIBINDO);
  assign troca      = troca_reg;

endmodule
